// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin shared-adder arbiter.
// Optional subtract support is enabled by defining ADDER_ARB_SUB_EN.
package adder_arb_pkg;

    localparam int DEF_WIDTH = 32;

    localparam int FLAG_V = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping, reported both one-hot and as an index.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] win_o,
    output logic [IDW-1:0]  win_id_o
);

    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  pos;
    logic [IDW:0]    abs_id;

    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    always_comb begin
        rot    = NREQ'({req_i, req_i} >> ptr_i);
        pos    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pos = IDW'(k);
            end
        end
        abs_id = {1'b0, ptr_i} + {1'b0, pos};
        if (abs_id >= (IDW + 1)'(NREQ)) begin
            abs_id = abs_id - (IDW + 1)'(NREQ);
        end
        win_id_o = abs_id[IDW-1:0];
        win_o    = |req_i ? (NREQ'(1) << win_id_o) : '0;
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one WIDTH-bit adder among NREQ requesters with round-robin arbitration.
// Define ADDER_ARB_SUB_EN to add the per-requester op_sub (A - B) input.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDW   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    input  logic [NREQ-1:0]       op_sign,
`ifdef ADDER_ARB_SUB_EN
    input  logic [NREQ-1:0]       op_sub,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      result,
    output logic [3:0]            flags
);

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sign_q, sign_d;
    logic             sub_q, sub_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic             valid_q, valid_d;

    logic [NREQ-1:0]  win;
    logic [IDW-1:0]   win_id;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_w;
    logic [3:0]       flags_w;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .win_o    (win),
        .win_id_o (win_id)
    );

    // Subtraction is A + ~B + 1, so carry out means "no borrow".
    always_comb begin
        b_eff   = sub_q ? ~b_q : b_q;
        sum_w   = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_q};
        flags_w = '0;
        flags_w[FLAG_C] = sum_w[WIDTH];
        flags_w[FLAG_Z] = (sum_w[WIDTH-1:0] == '0);
        flags_w[FLAG_N] = sign_q & sum_w[WIDTH-1];
        flags_w[FLAG_V] = sign_q
                        & (a_q[WIDTH-1] == b_eff[WIDTH-1])
                        & (sum_w[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        res_d   = res_q;
        flags_d = flags_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = EXEC;
                    gnt_d   = win;
                    id_d    = win_id;
                    for (int i = 0; i < NREQ; i++) begin
                        if (win[i]) begin
                            a_d    = op_a[i*WIDTH +: WIDTH];
                            b_d    = op_b[i*WIDTH +: WIDTH];
                            sign_d = op_sign[i];
`ifdef ADDER_ARB_SUB_EN
                            sub_d  = op_sub[i];
`else
                            sub_d  = 1'b0;
`endif
                        end
                    end
                end
            end
            EXEC: begin
                state_d = RESP;
                res_d   = sum_w[WIDTH-1:0];
                flags_d = flags_w;
                valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = valid_q;
    assign rsp_id    = id_q;
    assign result    = res_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized self-checking bench for adder_arbiter against a transaction-level model.
// Build with +define+ADDER_ARB_SUB_EN to also exercise subtraction.
module tb_adder_arbiter;

    localparam int NREQ  = 3;
    localparam int WIDTH = 32;
    localparam int IDW   = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       op_sign;
    logic [NREQ-1:0]       op_sub;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      result;
    logic [3:0]            flags;

    logic [WIDTH-1:0] ta [NREQ];
    logic [WIDTH-1:0] tb [NREQ];
    logic             ts [NREQ];
    logic             tu [NREQ];

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            op_a[i*WIDTH +: WIDTH] = ta[i];
            op_b[i*WIDTH +: WIDTH] = tb[i];
            op_sign[i]             = ts[i];
            op_sub[i]              = tu[i];
        end
    end

    adder_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sign   (op_sign),
`ifdef ADDER_ARB_SUB_EN
        .op_sub    (op_sub),
`endif
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .result    (result),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Returns {C,Z,N,V,result} from plain integer arithmetic.
    function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic u);
        logic [63:0] t;
        longint      sa, sb, st;
        logic [31:0] r;
        logic        v;
        t  = u ? ({32'd0, a} + 64'h1_0000_0000 - {32'd0, b}) : ({32'd0, a} + {32'd0, b});
        r  = t[31:0];
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        st = u ? sa - sb : sa + sb;
        v  = s && (st > 64'sd2147483647 || st < -64'sd2147483648);
        return {t[32], (r == 32'd0), s & r[31], v, r};
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge while the DUT is IDLE with req already driven.
    task automatic txn(input bit keep, input int stall);
        int          w;
        logic [35:0] e;
        w = pick(req, ptr_m);
        if (w < 0) begin
            check("txn_has_req", 64'(req), 64'd1);
            return;
        end
        e = ref_add(ta[w], tb[w], ts[w], tu[w]);
        @(negedge clk);
        check("gnt", 64'(gnt), 64'(3'b001 << w));
        check("busy_exec", 64'(busy), 64'd1);
        check("valid_exec", 64'(rsp_valid), 64'd0);
        if (!keep) begin
            req[w] = 1'b0;
            ta[w]  = $urandom;
            tb[w]  = $urandom;
        end
        @(negedge clk);
        check("valid_resp", 64'(rsp_valid), 64'd1);
        check("gnt_resp", 64'(gnt), 64'd0);
        check("result", 64'(result), 64'(e[31:0]));
        check("flags", 64'(flags), 64'(e[35:32]));
        check("rsp_id", 64'(rsp_id), 64'(w));
        if (stall > 0) begin
            rsp_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check("hold_valid", 64'(rsp_valid), 64'd1);
                check("hold_result", 64'(result), 64'(e[31:0]));
                check("hold_flags", 64'(flags), 64'(e[35:32]));
                check("hold_id", 64'(rsp_id), 64'(w));
                check("hold_gnt", 64'(gnt), 64'd0);
            end
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("valid_idle", 64'(rsp_valid), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("gnt_idle", 64'(gnt), 64'd0);
        ptr_m = (w + 1) % NREQ;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_gnt"}, 64'(gnt), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_id"}, 64'(rsp_id), 64'd0);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_flags"}, 64'(flags), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        rsp_ready = 1'b1;
        req       = '0;
        for (int i = 0; i < NREQ; i++) begin
            ta[i] = '0;
            tb[i] = '0;
            ts[i] = 1'b0;
            tu[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        ptr_m = 0;

        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h0000_0001; ts[0] = 1'b0;
        req   = 3'b001;
        txn(1'b0, 0);

        ta[1] = 32'h7FFF_FFFF; tb[1] = 32'h0000_0001; ts[1] = 1'b1;
        req   = 3'b010;
        txn(1'b0, 0);

        ta[0] = $urandom; tb[0] = $urandom; ts[0] = 1'b1;
        ta[1] = $urandom; tb[1] = $urandom; ts[1] = 1'b0;
        req   = 3'b011;
        repeat (4) txn(1'b1, 0);
        req   = '0;

        ta[2] = 32'h8000_0000; tb[2] = 32'h8000_0000; ts[2] = 1'b1;
        req   = 3'b100;
        txn(1'b0, 5);

        ta[0] = rnd32(); tb[0] = rnd32();
        ta[2] = rnd32(); tb[2] = rnd32();
        req   = 3'b101;
        txn(1'b0, 0);
        txn(1'b0, 0);

        @(negedge clk);
        check("idle_gnt", 64'(gnt), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        ta[0] = 32'd1; tb[0] = 32'd2;
        ta[1] = 32'd3; tb[1] = 32'd4;
        req   = 3'b011;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_valid", 64'(rsp_valid), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midresp");
        reset = 1'b0;
        ptr_m = 0;
        req   = 3'b010;
        txn(1'b0, 0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
        req   = 3'b011;
        txn(1'b0, 0);
        txn(1'b0, 0);

`ifdef ADDER_ARB_SUB_EN
        ta[0] = 32'd5; tb[0] = 32'd7; ts[0] = 1'b1; tu[0] = 1'b1;
        req   = 3'b001;
        txn(1'b0, 0);
`endif

        for (int it = 0; it < 200; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    ta[i]  = rnd32();
                    tb[i]  = rnd32();
                    ts[i]  = 1'($urandom_range(0, 1));
`ifdef ADDER_ARB_SUB_EN
                    tu[i]  = 1'($urandom_range(0, 1));
`endif
                    req[i] = 1'b1;
                end
            end
            if (req == '0) begin
                @(negedge clk);
                check("rand_idle_gnt", 64'(gnt), 64'd0);
                check("rand_idle_busy", 64'(busy), 64'd0);
            end else begin
                txn(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
